// File: rtl/scoreboard_display_mux.sv
// rtl/scoreboard_display_mux.sv - two-score BCD converter with multiplexed 4-digit scan
module scoreboard_display_mux #(
    parameter int REFRESH_DIV = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] score_a_i,
    input  logic [6:0] score_b_i,
    input  logic       display_en_i,
    output logic [3:0] digit_o,
    output logic [3:0] digit_en_o,
    output logic       conv_done_o
);

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_DIV_A  = 2'd1,
        S_DIV_B  = 2'd2,
        S_UPDATE = 2'd3
    } state_t;

    localparam logic [3:0]  BLANK      = 4'd15;
    localparam logic [15:0] PRESC_LAST = 16'(REFRESH_DIV - 1);

    state_t      r_state;
    logic [6:0]  r_rem_a;
    logic [6:0]  r_rem_b;
    logic [3:0]  r_tens_a;
    logic [3:0]  r_tens_b;
    logic [3:0]  r_disp3;
    logic [3:0]  r_disp2;
    logic [3:0]  r_disp1;
    logic [3:0]  r_disp0;
    logic        r_conv_done;
    logic [15:0] r_presc;
    logic [1:0]  r_scan_idx;
    logic [3:0]  r_digit;
    logic [3:0]  r_digit_en;

    logic [6:0]  w_clamp_a;
    logic [6:0]  w_clamp_b;
    logic [3:0]  w_sel_digit;

    assign w_clamp_a = (score_a_i > 7'd99) ? 7'd99 : score_a_i;
    assign w_clamp_b = (score_b_i > 7'd99) ? 7'd99 : score_b_i;

    // Converter: repeated subtraction by 10, one step per cycle, then commit all four digits at once
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_LOAD;
            r_rem_a     <= '0;
            r_rem_b     <= '0;
            r_tens_a    <= '0;
            r_tens_b    <= '0;
            r_disp3     <= BLANK;
            r_disp2     <= 4'd0;
            r_disp1     <= BLANK;
            r_disp0     <= 4'd0;
            r_conv_done <= 1'b0;
        end else begin
            r_conv_done <= 1'b0;
            case (r_state)
                S_LOAD: begin
                    r_rem_a  <= w_clamp_a;
                    r_rem_b  <= w_clamp_b;
                    r_tens_a <= '0;
                    r_tens_b <= '0;
                    r_state  <= S_DIV_A;
                end
                S_DIV_A: begin
                    if (r_rem_a >= 7'd10) begin
                        r_rem_a  <= r_rem_a - 7'd10;
                        r_tens_a <= r_tens_a + 4'd1;
                    end else begin
                        r_state <= S_DIV_B;
                    end
                end
                S_DIV_B: begin
                    if (r_rem_b >= 7'd10) begin
                        r_rem_b  <= r_rem_b - 7'd10;
                        r_tens_b <= r_tens_b + 4'd1;
                    end else begin
                        r_state <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    r_disp3     <= (r_tens_a == 4'd0) ? BLANK : r_tens_a;
                    r_disp2     <= r_rem_a[3:0];
                    r_disp1     <= (r_tens_b == 4'd0) ? BLANK : r_tens_b;
                    r_disp0     <= r_rem_b[3:0];
                    r_conv_done <= 1'b1;
                    r_state     <= S_LOAD;
                end
                default: r_state <= S_LOAD;
            endcase
        end
    end

    // Prescaler sets how long each digit stays lit; scan index advances on its wrap
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_presc    <= '0;
            r_scan_idx <= '0;
        end else if (r_presc == PRESC_LAST) begin
            r_presc    <= '0;
            r_scan_idx <= r_scan_idx + 2'd1;
        end else begin
            r_presc <= r_presc + 16'd1;
        end
    end

    // Pick the display register for the current scan position
    always_comb begin
        w_sel_digit = BLANK;
        case (r_scan_idx)
            2'd0: w_sel_digit = r_disp0;
            2'd1: w_sel_digit = r_disp1;
            2'd2: w_sel_digit = r_disp2;
            2'd3: w_sel_digit = r_disp3;
            default: w_sel_digit = BLANK;
        endcase
    end

    // Register the digit drive so a commit and a scan step on the same edge never tear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_digit    <= BLANK;
            r_digit_en <= 4'b0000;
        end else if (display_en_i) begin
            r_digit    <= w_sel_digit;
            r_digit_en <= 4'b0001 << r_scan_idx;
        end else begin
            r_digit    <= BLANK;
            r_digit_en <= 4'b0000;
        end
    end

    assign digit_o     = r_digit;
    assign digit_en_o  = r_digit_en;
    assign conv_done_o = r_conv_done;

endmodule

// File: tb/tb_scoreboard_display_mux.sv
// tb/tb_scoreboard_display_mux.sv - directed self-checking bench for scoreboard_display_mux
module tb_scoreboard_display_mux;

    logic       clk;
    logic       rst_n;
    logic [6:0] score_a_i;
    logic [6:0] score_b_i;
    logic       display_en_i;
    logic [3:0] digit_o;
    logic [3:0] digit_en_o;
    logic       conv_done_o;

    int checks   = 0;
    int failures = 0;
    logic [3:0] seen [4];

    scoreboard_display_mux #(.REFRESH_DIV(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .score_a_i    (score_a_i),
        .score_b_i    (score_b_i),
        .display_en_i (display_en_i),
        .digit_o      (digit_o),
        .digit_en_o   (digit_en_o),
        .conv_done_o  (conv_done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] rotl(input logic [3:0] v, input int k);
        logic [3:0] r;
        r = v;
        for (int i = 0; i < k; i++) r = {r[2:0], r[3]};
        return r;
    endfunction

    task automatic wait_done(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!conv_done_o && n < 40);
        chk("done_seen", int'(conv_done_o), 1);
    endtask

    task automatic capture(input bit no_done);
        for (int p = 0; p < 4; p++) seen[p] = 4'd14;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("onehot0", int'($onehot0(digit_en_o)), 1);
            if (no_done) chk("no_done", int'(conv_done_o), 0);
            for (int p = 0; p < 4; p++)
                if (digit_en_o[p]) seen[p] = digit_o;
        end
    endtask

    task automatic check_pos(input string tag, input int d3, input int d2, input int d1, input int d0);
        chk({tag, "_pos3"}, int'(seen[3]), d3);
        chk({tag, "_pos2"}, int'(seen[2]), d2);
        chk({tag, "_pos1"}, int'(seen[1]), d1);
        chk({tag, "_pos0"}, int'(seen[0]), d0);
    endtask

    initial begin
        int n;
        logic [3:0] en_before;
        logic [3:0] prev;

        rst_n        = 1'b0;
        score_a_i    = 7'd0;
        score_b_i    = 7'd0;
        display_en_i = 1'b1;
        tick(); tick(); tick();
        chk("rst_digit", int'(digit_o), 15);
        chk("rst_en", int'(digit_en_o), 0);
        chk("rst_done", int'(conv_done_o), 0);

        // release: edge0 LOAD, edge3 UPDATE and first prescaler wrap
        rst_n = 1'b1;
        tick();
        chk("r0_en", int'(digit_en_o), 1);
        chk("r0_digit", int'(digit_o), 0);
        chk("r0_done", int'(conv_done_o), 0);
        tick(); tick();
        chk("r2_done", int'(conv_done_o), 0);
        chk("r2_en", int'(digit_en_o), 1);
        tick();
        chk("r3_done", int'(conv_done_o), 1);
        chk("r3_en", int'(digit_en_o), 1);
        tick();
        chk("r4_done", int'(conv_done_o), 0);
        chk("r4_en", int'(digit_en_o), 2);
        chk("r4_digit", int'(digit_o), 15);
        tick(); tick(); tick(); tick();
        chk("r8_en", int'(digit_en_o), 4);
        chk("r8_digit", int'(digit_o), 0);
        tick(); tick(); tick(); tick();
        chk("r12_en", int'(digit_en_o), 8);
        chk("r12_digit", int'(digit_o), 15);

        // 37 / 5
        score_a_i = 7'd37;
        score_b_i = 7'd5;
        wait_done(n);
        wait_done(n);
        chk("spacing_37_5", n, 7);
        capture(1'b0);
        check_pos("s37_5", 3, 7, 15, 5);

        // clamp 120 / 99
        score_a_i = 7'd120;
        score_b_i = 7'd99;
        wait_done(n);
        wait_done(n);
        chk("spacing_99_99", n, 22);
        capture(1'b0);
        check_pos("s99", 9, 9, 9, 9);

        // change 12 -> 88 just after LOAD
        score_a_i = 7'd12;
        score_b_i = 7'd12;
        wait_done(n);
        tick();
        score_a_i = 7'd88;
        score_b_i = 7'd88;
        wait_done(n);
        chk("spacing_12_rest", n, 5);
        capture(1'b0);
        check_pos("s12", 1, 2, 1, 2);
        wait_done(n);
        chk("spacing_88_rest", n, 4);
        capture(1'b0);
        check_pos("s88", 8, 8, 8, 8);

        // display disable for 10 cycles from a slot boundary
        prev = digit_en_o;
        n = 0;
        do begin
            tick();
            n++;
        end while (digit_en_o == prev && n < 10);
        chk("slot_edge_found", int'(digit_en_o != prev), 1);
        en_before = digit_en_o;
        display_en_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("dis_en", int'(digit_en_o), 0);
            chk("dis_digit", int'(digit_o), 15);
        end
        display_en_i = 1'b1;
        tick();
        chk("reen_en_a", int'(digit_en_o), int'(rotl(en_before, 2)));
        chk("reen_digit_a", int'(digit_o), 8);
        tick();
        chk("reen_en_b", int'(digit_en_o), int'(rotl(en_before, 3)));

        // reset during DIV_B of an 88/88 conversion
        wait_done(n);
        for (int i = 0; i < 12; i++) tick();
        rst_n = 1'b0;
        tick();
        chk("mid_rst_done", int'(conv_done_o), 0);
        chk("mid_rst_en", int'(digit_en_o), 0);
        chk("mid_rst_digit", int'(digit_o), 15);
        tick();
        chk("mid_rst_done2", int'(conv_done_o), 0);
        rst_n = 1'b1;
        capture(1'b1);
        check_pos("post_rst", 15, 0, 15, 0);
        wait_done(n);
        chk("post_rst_first_conv", n, 4);
        capture(1'b0);
        check_pos("post_rst_88", 8, 8, 8, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
